// File: rtl/spmv_axi_pkg.sv
// Shared AXI4 widths, burst/response encodings and engine state types for the SpMV memory responder.
// Pure declarations: no latency, no flow control.
package spmv_axi_pkg;
  localparam int AXI_ADDR_W = 48;
  localparam int AXI_DATA_W = 256;
  localparam int AXI_STRB_W = 32;
  localparam logic [2:0] AXI_SIZE_FULL = 3'd5;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // Any address bit above the word index makes the burst out of range.
  function automatic logic addr_out_of_range(input logic [AXI_ADDR_W-1:0] addr,
                                             input int depth_log2);
    return (addr >> (5 + depth_log2)) != '0;
  endfunction
endpackage

// File: rtl/spmv_axi_skid_buf.sv
// 2-entry valid/ready buffer, fall-through when empty (0 cycles), registered when holding.
// Holds payload stable while out_rdy is low; upstream must keep count+in-flight within 2.
module spmv_axi_skid_buf #(
  parameter int WIDTH = 259
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] entry_q [2];
  logic             rd_ptr, wr_ptr;
  logic             empty, pass, push, pop;

  assign empty   = (count == 2'd0);
  assign pass    = empty && in_vld && out_rdy;
  assign push    = in_vld && !pass;
  assign pop     = !empty && out_rdy;
  assign out_vld = !empty || in_vld;
  assign out_dat = !empty ? entry_q[rd_ptr] : (in_vld ? in_dat : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) entry_q[wr_ptr] <= in_dat;
  end
endmodule

// File: rtl/spmv_axi_mem_responder.sv
// AXI4 slave over a 256-bit dual-port array; independent read/write engines, one burst each.
// First R beat 2 cycles after AR; B 1 cycle after last W; R stalls absorbed by a 2-entry skid.
module spmv_axi_mem_responder
  import spmv_axi_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
  input  logic [1:0]            s_axi_arburst,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [AXI_DATA_W-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
  input  logic [1:0]            s_axi_awburst,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [AXI_DATA_W-1:0] s_axi_wdata,
  input  logic [AXI_STRB_W-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BEAT_W = AXI_DATA_W + 3;
  typedef logic [DEPTH_LOG2-1:0] idx_t;

  logic [AXI_DATA_W-1:0] mem [DEPTH];
  logic [AXI_DATA_W-1:0] ram_q;

  rd_state_t   r_state, r_state_nxt;
  idx_t        r_idx;
  logic [7:0]  r_len, r_beat;
  burst_t      r_burst;
  logic        r_err, r_issued_all, ar_rdy, ar_fire, r_fire, r_issue;
  logic        rd_pend, rd_pend_last, rd_pend_err;
  logic [1:0]  sk_count;
  logic [2:0]  r_occ;
  logic [BEAT_W-1:0] sk_in_dat, sk_out_dat;

  assign s_axi_arready = ar_rdy;
  assign ar_fire = s_axi_arvalid && ar_rdy;
  assign r_fire  = s_axi_rvalid && s_axi_rready;
  // Skid entries plus the beat in the RAM pipe, less the one leaving now, must stay within 2.
  assign r_occ   = {1'b0, sk_count} + {2'b0, rd_pend} - {2'b0, r_fire};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      ar_rdy  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      ar_rdy  <= (r_state_nxt == R_IDLE);
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    r_issue     = 1'b0;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_nxt = R_BURST;
      R_BURST: begin
        r_issue = !r_issued_all && (r_occ <= 3'd1);
        if (r_fire && s_axi_rlast) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_burst      <= INCR;
      r_err        <= 1'b0;
      r_issued_all <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      rd_pend_err  <= 1'b0;
    end else begin
      rd_pend <= r_issue;
      if (ar_fire) begin
        r_idx        <= s_axi_araddr[5 +: DEPTH_LOG2];
        r_len        <= s_axi_arlen;
        r_beat       <= '0;
        r_burst      <= burst_t'(s_axi_arburst);
        r_err        <= (s_axi_arsize != AXI_SIZE_FULL) ||
                        addr_out_of_range(s_axi_araddr, DEPTH_LOG2);
        r_issued_all <= 1'b0;
      end else if (r_issue) begin
        rd_pend_last <= (r_beat == r_len);
        rd_pend_err  <= r_err;
        r_issued_all <= (r_beat == r_len);
        r_beat       <= r_beat + 8'd1;
        if (r_burst != FIXED) r_idx <= r_idx + idx_t'(1);
      end
    end
  end

  assign sk_in_dat = {rd_pend_err ? {AXI_DATA_W{1'b0}} : ram_q,
                      rd_pend_err ? SLVERR : OKAY,
                      rd_pend_last};

  spmv_axi_skid_buf #(.WIDTH(BEAT_W)) u_rbuf (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_pend),
    .in_dat  (sk_in_dat),
    .out_vld (s_axi_rvalid),
    .out_rdy (s_axi_rready),
    .out_dat (sk_out_dat),
    .count   (sk_count)
  );

  assign {s_axi_rdata, s_axi_rresp, s_axi_rlast} = sk_out_dat;

  wr_state_t  w_state, w_state_nxt;
  idx_t       w_idx;
  logic [7:0] w_len, w_beat;
  burst_t     w_burst;
  logic       w_err, w_last_err, aw_rdy, aw_fire, w_fire, w_final, w_we;

  assign s_axi_awready = aw_rdy;
  assign aw_fire = s_axi_awvalid && aw_rdy;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  assign w_final = (w_beat == w_len);
  assign w_we    = w_fire && !w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_rdy  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      aw_rdy  <= (w_state_nxt == W_IDLE);
    end
  end

  always_comb begin
    w_state_nxt  = w_state;
    s_axi_wready = 1'b0;
    s_axi_bvalid = 1'b0;
    s_axi_bresp  = OKAY;
    case (w_state)
      W_IDLE: if (aw_fire) w_state_nxt = W_DATA;
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_final) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = (w_err || w_last_err) ? SLVERR : OKAY;
        if (s_axi_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_idx      <= '0;
      w_len      <= '0;
      w_beat     <= '0;
      w_burst    <= INCR;
      w_err      <= 1'b0;
      w_last_err <= 1'b0;
    end else if (aw_fire) begin
      w_idx      <= s_axi_awaddr[5 +: DEPTH_LOG2];
      w_len      <= s_axi_awlen;
      w_beat     <= '0;
      w_burst    <= burst_t'(s_axi_awburst);
      w_err      <= (s_axi_awsize != AXI_SIZE_FULL) ||
                    addr_out_of_range(s_axi_awaddr, DEPTH_LOG2);
      w_last_err <= 1'b0;
    end else if (w_fire) begin
      if (s_axi_wlast != w_final) w_last_err <= 1'b1;
      w_beat <= w_beat + 8'd1;
      if (w_burst != FIXED) w_idx <= w_idx + idx_t'(1);
    end
  end

  // Nonblocking read and write of the same word in one cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (r_issue) ram_q <= mem[r_idx];
    if (w_we) begin
      for (int b = 0; b < AXI_STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_spmv_axi_mem_responder.sv
// Directed bench for spmv_axi_mem_responder: preload, bursts, stalls, strobes, errors, reset.
module tb_spmv_axi_mem_responder;
  localparam logic [1:0] B_FIXED  = 2'b00;
  localparam logic [1:0] B_INCR   = 2'b01;
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_SLV = 2'b10;

  logic         clk, rst;
  logic [47:0]  s_axi_araddr, s_axi_awaddr;
  logic [1:0]   s_axi_arburst, s_axi_awburst, s_axi_rresp, s_axi_bresp;
  logic [7:0]   s_axi_arlen, s_axi_awlen;
  logic [2:0]   s_axi_arsize, s_axi_awsize;
  logic         s_axi_arvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic         s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic         s_axi_bvalid, s_axi_bready;
  logic [255:0] s_axi_rdata, s_axi_wdata;
  logic [31:0]  s_axi_wstrb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [255:0] got_data [$];
  logic [1:0]   got_resp [$];
  logic         got_last [$];
  int first_lat, last_lat, stall_bad, rd_t0, aw_t0, b_lat;
  logic [1:0] b_resp;

  spmv_axi_mem_responder #(.DEPTH_LOG2(12)) dut (
    .clk(clk), .rst(rst),
    .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awburst(s_axi_awburst), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic read_burst(input logic [47:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] pat);
    int n;
    logic [258:0] held;
    logic held_vld;
    got_data.delete(); got_resp.delete(); got_last.delete();
    first_lat = -1; last_lat = -1; stall_bad = 0; held_vld = 1'b0; held = '0;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst; s_axi_arsize = size;
    s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    n = 0;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    rd_t0 = cyc;
    tick();
    s_axi_arvalid = 1'b0;
    for (int j = 0; j < 300 && got_data.size() < int'(len) + 1; j++) begin
      s_axi_rready = pat[j % 4];
      if (s_axi_rvalid) begin
        if (first_lat < 0) first_lat = cyc - rd_t0;
        if (held_vld && held !== {s_axi_rdata, s_axi_rresp, s_axi_rlast}) stall_bad++;
        if (s_axi_rready) begin
          got_data.push_back(s_axi_rdata); got_resp.push_back(s_axi_rresp);
          got_last.push_back(s_axi_rlast);
          held_vld = 1'b0;
          last_lat = cyc - rd_t0;
        end else begin
          held_vld = 1'b1;
          held = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
        end
      end
      tick();
    end
    s_axi_rready = 1'b1;
  endtask

  task automatic write_beats(input logic [47:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [255:0] base, input logic [31:0] strb,
                             input int wlast_at);
    int n, wt;
    b_resp = 2'bxx; b_lat = -1; wt = 0;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst; s_axi_awsize = size;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    aw_t0 = cyc;
    tick();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = base + 256'(i); s_axi_wstrb = strb; s_axi_wlast = (i == wlast_at);
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin tick(); n++; end
      wt = cyc;
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin tick(); n++; end
    if (s_axi_bvalid) begin b_lat = cyc - wt; b_resp = s_axi_bresp; end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if ({s_axi_arready, s_axi_awready, s_axi_wready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b expected 000", {s_axi_arready, s_axi_awready, s_axi_wready}); end
    checks++; if ({s_axi_rvalid, s_axi_bvalid, s_axi_rlast} !== 3'b000) begin
      errors++; $display("FAIL reset_valid: got %b expected 000", {s_axi_rvalid, s_axi_bvalid, s_axi_rlast}); end
    checks++; if (s_axi_rdata !== '0 || s_axi_rresp !== 2'b00 || s_axi_bresp !== 2'b00) begin
      errors++; $display("FAIL reset_payload: rdata %h rresp %b bresp %b expected zero", s_axi_rdata, s_axi_rresp, s_axi_bresp); end
    rst = 1'b0;
    tick();
    checks++; if ({s_axi_arready, s_axi_awready} !== 2'b11) begin
      errors++; $display("FAIL reset_release: got %b expected 11", {s_axi_arready, s_axi_awready}); end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 8; i++) begin
      write_beats(48'(i) << 5, 8'd0, B_INCR, 3'd5, 256'(i), 32'hFFFF_FFFF, 0);
      checks++; if (b_resp !== RESP_OK || b_lat != 1) begin
        errors++; $display("FAIL preload_b[%0d]: resp %b lat %0d expected 00 lat 1", i, b_resp, b_lat); end
    end
  endtask

  task automatic test_incr_read();
    read_burst(48'd0, 8'd7, B_INCR, 3'd5, 4'b1111);
    checks++; if (got_data.size() != 8) begin
      errors++; $display("FAIL incr_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== 256'(i) || got_resp[i] !== RESP_OK || got_last[i] !== (i == 7)) begin
        errors++; $display("FAIL incr_beat[%0d]: got %h/%b/%b expected %0d/00/%b", i, got_data[i], got_resp[i], got_last[i], i, i == 7); end
    end
    checks++; if (first_lat != 2 || last_lat != 9) begin
      errors++; $display("FAIL incr_latency: first %0d last %0d expected 2 and 9", first_lat, last_lat); end
  endtask

  task automatic test_stall_read();
    read_burst(48'd0, 8'd7, B_INCR, 3'd5, 4'b1001);
    checks++; if (got_data.size() != 8) begin
      errors++; $display("FAIL stall_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== 256'(i) || got_last[i] !== (i == 7)) begin
        errors++; $display("FAIL stall_beat[%0d]: got %h/%b expected %0d/%b", i, got_data[i], got_last[i], i, i == 7); end
    end
    checks++; if (stall_bad != 0) begin
      errors++; $display("FAIL stall_hold: got %0d payload changes expected 0", stall_bad); end
  endtask

  task automatic test_strobe();
    logic [255:0] exp [3];
    exp[0] = 256'd2; exp[1] = 256'hFFFF_FFFF; exp[2] = 256'd4;
    write_beats(48'd3 << 5, 8'd0, B_INCR, 3'd5, {256{1'b1}}, 32'h0000_000F, 0);
    checks++; if (b_resp !== RESP_OK || b_lat != 1) begin
      errors++; $display("FAIL strobe_b: resp %b lat %0d expected 00 lat 1", b_resp, b_lat); end
    read_burst(48'd2 << 5, 8'd2, B_INCR, 3'd5, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      checks++; if (i >= got_data.size() || got_data[i] !== exp[i]) begin
        errors++; $display("FAIL strobe_word[%0d]: got %h expected %h", i, (i < got_data.size()) ? got_data[i] : 'x, exp[i]); end
    end
  endtask

  task automatic test_errors();
    logic [255:0] exp [8];
    exp = '{256'd0, 256'd1, 256'd2, 256'hFFFF_FFFF, 256'd4, 256'd5, 256'd6, 256'd7};
    read_burst(48'd0, 8'd1, B_INCR, 3'd4, 4'b1111);
    checks++; if (got_data.size() != 2) begin
      errors++; $display("FAIL size_err_count: got %0d expected 2", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== '0 || got_resp[i] !== RESP_SLV || got_last[i] !== (i == 1)) begin
        errors++; $display("FAIL size_err_beat[%0d]: got %h/%b/%b expected 0/10/%b", i, got_data[i], got_resp[i], got_last[i], i == 1); end
    end
    read_burst(48'd1 << 17, 8'd0, B_INCR, 3'd5, 4'b1111);
    checks++; if (got_data.size() != 1 || got_data[0] !== '0 || got_resp[0] !== RESP_SLV || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL range_err: got %0d beats resp %b expected 1 beat zero data resp 10 rlast", got_data.size(), (got_data.size() > 0) ? got_resp[0] : 2'bxx); end
    write_beats(48'd6 << 5, 8'd0, B_INCR, 3'd4, {256{1'b1}}, 32'hFFFF_FFFF, 0);
    checks++; if (b_resp !== RESP_SLV) begin
      errors++; $display("FAIL aw_size_err: bresp %b expected 10", b_resp); end
    read_burst(48'd0, 8'd7, B_INCR, 3'd5, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      checks++; if (i >= got_data.size() || got_data[i] !== exp[i]) begin
        errors++; $display("FAIL err_unchanged[%0d]: got %h expected %h", i, (i < got_data.size()) ? got_data[i] : 'x, exp[i]); end
    end
  endtask

  task automatic test_wlast_mismatch();
    write_beats(48'd4 << 5, 8'd3, B_INCR, 3'd5, 256'hA0, 32'hFFFF_FFFF, 1);
    checks++; if (b_resp !== RESP_SLV || b_lat != 1) begin
      errors++; $display("FAIL wlast_b: resp %b lat %0d expected 10 lat 1", b_resp, b_lat); end
    read_burst(48'd5 << 5, 8'd3, B_FIXED, 3'd5, 4'b1111);
    checks++; if (got_data.size() != 4) begin
      errors++; $display("FAIL fixed_count: got %0d expected 4", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== 256'hA1 || got_resp[i] !== RESP_OK || got_last[i] !== (i == 3)) begin
        errors++; $display("FAIL fixed_beat[%0d]: got %h/%b/%b expected a1/00/%b", i, got_data[i], got_resp[i], got_last[i], i == 3); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int n, beats;
    logic [255:0] exp [8];
    exp = '{256'd0, 256'd1, 256'd2, 256'hFFFF_FFFF, 256'hA0, 256'hA1, 256'hA2, 256'hA3};
    s_axi_araddr = 48'd0; s_axi_arlen = 8'd7; s_axi_arburst = B_INCR; s_axi_arsize = 3'd5;
    s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    tick();
    s_axi_arvalid = 1'b0;
    beats = 0; n = 0;
    while (beats < 2 && n < 50) begin if (s_axi_rvalid) beats++; tick(); n++; end
    checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 256'd2) begin
      errors++; $display("FAIL midrst_beat2: rvalid %b data %h expected 1 and 2", s_axi_rvalid, s_axi_rdata); end
    rst = 1'b1;
    #1;
    checks++; if ({s_axi_rvalid, s_axi_arready, s_axi_bvalid} !== 3'b000) begin
      errors++; $display("FAIL midrst_abort: got %b expected 000", {s_axi_rvalid, s_axi_arready, s_axi_bvalid}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: arready %b rvalid %b expected 1 and 0", s_axi_arready, s_axi_rvalid); end
    read_burst(48'd0, 8'd7, B_INCR, 3'd5, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      checks++; if (i >= got_data.size() || got_data[i] !== exp[i]) begin
        errors++; $display("FAIL midrst_data[%0d]: got %h expected %h", i, (i < got_data.size()) ? got_data[i] : 'x, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    fork
      read_burst(48'd1 << 5, 8'd0, B_INCR, 3'd5, 4'b1111);
      write_beats(48'd9 << 5, 8'd0, B_INCR, 3'd5, 256'h55, 32'hFFFF_FFFF, 0);
    join
    checks++; if (rd_t0 != aw_t0) begin
      errors++; $display("FAIL dual_accept: ar cycle %0d aw cycle %0d expected equal", rd_t0, aw_t0); end
    checks++; if (got_data.size() != 1 || got_data[0] !== 256'd1 || b_resp !== RESP_OK) begin
      errors++; $display("FAIL dual_result: beats %0d bresp %b expected 1 beat of 1 and bresp 00", got_data.size(), b_resp); end
    read_burst(48'd9 << 5, 8'd0, B_INCR, 3'd5, 4'b1111);
    checks++; if (got_data.size() != 1 || got_data[0] !== 256'h55) begin
      errors++; $display("FAIL dual_readback: got %h expected 55", (got_data.size() > 0) ? got_data[0] : 'x); end
  endtask

  initial begin
    rst = 1'b1;
    s_axi_araddr = '0; s_axi_arburst = B_INCR; s_axi_arlen = '0; s_axi_arsize = 3'd5; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    s_axi_awaddr = '0; s_axi_awburst = B_INCR; s_axi_awlen = '0; s_axi_awsize = 3'd5; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    test_reset();
    test_preload();
    test_incr_read();
    test_stall_read();
    test_strobe();
    test_errors();
    test_wlast_mismatch();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
